regs_mp_sb: RTL

- Parametrised successor to the core general-purpose register file.
- Adds N combinational read ports and two write ports: ex writeback (wp0) and long-latency writeback (wp1, load/div).
- Adds a per-register busy scoreboard for long-latency destinations.
- Replaces the raw jtag write strobe with a req/ack-handshaked debug port that never contends with pipeline writes.
- Sits between id (reads, allocation) and ex/wb (writes); the jtag module drives the debug port.

---
 rtl/regs_mp_sb.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/regs_mp_sb.sv
// Multi-ported general-purpose register file with ex/long-latency writeback,
// a busy scoreboard for long-latency destinations and a handshaked debug port.
//
// Debug port FSM:
//   state  | meaning
//   IDLE   | no access in flight; waits for req (after req has been seen low)
//   WAIT   | access accepted; writes wait for a cycle free of pipeline writes
//   ACK    | one-cycle completion pulse on jtag_ack_o
module regs_mp_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*ADDR_W-1:0] raddr_i,
  output logic [NRD*DATA_W-1:0] rdata_o,
  output logic [NRD-1:0]        rbusy_o,
  input  logic                  wp0_we_i,
  input  logic [ADDR_W-1:0]     wp0_addr_i,
  input  logic [DATA_W-1:0]     wp0_data_i,
  input  logic                  wp1_we_i,
  input  logic [ADDR_W-1:0]     wp1_addr_i,
  input  logic [DATA_W-1:0]     wp1_data_i,
  input  logic                  alloc_i,
  input  logic [ADDR_W-1:0]     alloc_addr_i,
  input  logic                  jtag_req_i,
  input  logic                  jtag_we_i,
  input  logic [ADDR_W-1:0]     jtag_addr_i,
  input  logic [DATA_W-1:0]     jtag_data_i,
  output logic                  jtag_ack_o,
  output logic [DATA_W-1:0]     jtag_data_o
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [1:0]          state;
  logic                armed;
  logic                jtag_wr_go;
  logic                jtag_rd_go;

  // Debug writes only slip in on cycles with no pipeline write, so they never contend.
  assign jtag_wr_go = (state == S_WAIT) && jtag_we_i && !wp0_we_i && !wp1_we_i;
  assign jtag_rd_go = (state == S_WAIT) && !jtag_we_i;
  assign jtag_ack_o = (state == S_ACK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (wp0_we_i && wp0_addr_i == ADDR_W'(i)) begin
          regs[i] <= wp0_data_i;
        end else if (wp1_we_i && wp1_addr_i == ADDR_W'(i)) begin
          regs[i] <= wp1_data_i;
        end else if (jtag_wr_go && jtag_addr_i == ADDR_W'(i)) begin
          regs[i] <= jtag_data_i;
        end
      end
    end
  end

  // A fresh allocation outranks the writeback retiring the previous one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy[0] <= 1'b0;
      for (int i = 1; i < NUM_REGS; i++) begin
        if (alloc_i && alloc_addr_i == ADDR_W'(i)) begin
          busy[i] <= 1'b1;
        end else if (wp1_we_i && wp1_addr_i == ADDR_W'(i)) begin
          busy[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      armed       <= 1'b0;
      jtag_data_o <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (jtag_req_i && armed) begin
            state <= S_WAIT;
            armed <= 1'b0;
          end else if (!jtag_req_i) begin
            armed <= 1'b1;
          end
        end
        S_WAIT: begin
          if (jtag_rd_go) begin
            jtag_data_o <= regs[jtag_addr_i];
            state       <= S_ACK;
          end else if (jtag_wr_go) begin
            state <= S_ACK;
          end
        end
        S_ACK:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  genvar k;
  generate
    for (k = 0; k < NRD; k++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rd;
      logic              rb;
      logic              wp0_hit;
      logic              wp1_hit;

      assign ra      = raddr_i[k*ADDR_W +: ADDR_W];
      assign wp0_hit = wp0_we_i && (wp0_addr_i == ra);
      assign wp1_hit = wp1_we_i && (wp1_addr_i == ra);

      always_comb begin
        rd = '0;
        rb = 1'b0;
        if (!rst && ra != '0) begin
          if (wp0_hit) begin
            rd = wp0_data_i;
          end else if (wp1_hit) begin
            rd = wp1_data_i;
          end else begin
            rd = regs[ra];
          end
          rb = busy[ra] && !wp1_hit;
        end
      end

      assign rdata_o[k*DATA_W +: DATA_W] = rd;
      assign rbusy_o[k]                  = rb;
    end
  endgenerate

endmodule
